// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults and pointer type for the sync_fifo_rd FIFO slice.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 2;

    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Brief    : Wrapping FIFO pointer; the MSB is the lap bit, the low bits index storage.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/sync_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_rd
// Brief    : Single-clock FIFO with registered read data and overflow/underflow
//            pulses. Define SYNC_FIFO_RD_COUNT_EN to add the `count` output.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_rd
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_RD_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH:0]   w_wptr;
    logic [ADDR_WIDTH:0]   w_rptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_overflow;
    logic                  r_underflow;

    // Same slot with opposite lap bits means the writer is one full lap ahead.
    assign w_empty  = (w_wptr == w_rptr);
    assign w_full   = (w_wptr[ADDR_WIDTH-1:0] == w_rptr[ADDR_WIDTH-1:0]) &&
                      (w_wptr[ADDR_WIDTH] != w_rptr[ADDR_WIDTH]);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_wptr (
        .clk   (clk),
        .rst   (reset),
        .i_inc (w_wr_acc),
        .o_ptr (w_wptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_rptr (
        .clk   (clk),
        .rst   (reset),
        .i_inc (w_rd_acc),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wptr[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rdata <= r_mem[w_rptr[ADDR_WIDTH-1:0]];
            end
            r_overflow  <= wr_en & w_full;
            r_underflow <= rd_en & w_empty;
        end
    end

    assign rdata     = r_rdata;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef SYNC_FIFO_RD_COUNT_EN
    assign count = w_wptr - w_rptr;
`endif

endmodule : sync_fifo_rd
`default_nettype wire

// File: tb/tb_sync_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_rd
// Brief    : Self-checking bench for sync_fifo_rd (DEPTH=4): directed vector
//            table, hand sequences and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_rd;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
`ifdef SYNC_FIFO_RD_COUNT_EN
    logic [2:0]    count;
`endif

    sync_fifo_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .rd_en     (rd_en),
        .rdata     (rdata),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef SYNC_FIFO_RD_COUNT_EN
        ,
        .count     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored words as a queue, plus expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;
    logic          m_ovf;
    logic          m_unf;

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        logic [DW-1:0] e_rdata;
        logic          e_full;
        logic          e_empty;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rdata"},     rdata,     m_rdata);
        chk({tag, ".full"},      {31'd0, full},      {31'd0, (q.size() == DEPTH)});
        chk({tag, ".empty"},     {31'd0, empty},     {31'd0, (q.size() == 0)});
        chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
        chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_unf});
`ifdef SYNC_FIFO_RD_COUNT_EN
        chk({tag, ".count"},     {29'd0, count},     q.size());
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock: drive at negedge, apply FIFO rules at the posedge, check 1 ns later.
    task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input string tag);
        int sz;
        @(negedge clk);
        wr_en = wr;
        wdata = wd;
        rd_en = rd;
        @(posedge clk);
        sz    = q.size();
        m_ovf = wr && (sz == DEPTH);
        m_unf = rd && (sz == 0);
        if (rd && sz > 0) m_rdata = q.pop_front();
        if (wr && sz < DEPTH) q.push_back(wd);
        #1;
        chk_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    wdata   rd    rdata   full  empty ovf   unf
        tbl[0]  = '{1'b1, 32'h11, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h22, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h33, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h44, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h55, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h00, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h00, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 32'h00, 1'b0, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'hAA, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 32'hAA, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        wr_en = 1'b0;
        wdata = '0;
        rd_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then idle for 5 cycles.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, "idle");

        // Directed vectors: fill, overflow, drain, underflow, write+read on empty.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].wr, tbl[i].wd, tbl[i].rd, "tbl_model");
            chk($sformatf("tbl%0d.rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d.full", i),  {31'd0, full},  {31'd0, tbl[i].e_full});
            chk($sformatf("tbl%0d.empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
            chk($sformatf("tbl%0d.ovf", i),   {31'd0, overflow},  {31'd0, tbl[i].e_ovf});
            chk($sformatf("tbl%0d.unf", i),   {31'd0, underflow}, {31'd0, tbl[i].e_unf});
        end

        // Wrap-around: occupancy held at 2 while 10 values stream through.
        step(1'b1, 32'h1, 1'b0, "wrap_w");
        step(1'b1, 32'h2, 1'b0, "wrap_w");
        for (int i = 3; i <= 10; i++) begin
            step(1'b1, 32'(i), 1'b1, "wrap_wr");
            chk("wrap.order", rdata, 32'(i - 2));
        end
        step(1'b0, '0, 1'b1, "wrap_r");
        chk("wrap.tail9", rdata, 32'h9);
        step(1'b0, '0, 1'b1, "wrap_r");
        chk("wrap.tail10", rdata, 32'hA);

        // Async reset mid-stream with 3 words stored and rdata non-zero.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, "pre_rst");
        step(1'b0, '0, 1'b1, "pre_rst_rd");
        chk("pre_rst.rdata", rdata, 32'hC0);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.rdata", rdata, 32'h0);
        chk("async_rst.empty", {31'd0, empty}, 32'd1);
        chk("async_rst.full",  {31'd0, full},  32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h77, 1'b0, "post_rst_w");
        step(1'b0, '0, 1'b1, "post_rst_r");
        chk("post_rst.rdata", rdata, 32'h77);

        // Random traffic against the queue model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "rand");
        end

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_rd
`default_nettype wire

// File: doc/sync_fifo_rd.md
Name: sync_fifo_rd

Overview:
- Synchronous 32-bit FIFO that buffers words from a producer and returns them in order through a registered read port.
- The `rdata` output behaves like a clocked register: updated only on an accepted read, otherwise held.
- Sits between a write-side datapath stage and a consumer in the memory subsystem, on a single clock domain.

Parameters:
- DATA_WIDTH, 32, width of stored words and of `wdata`/`rdata`.
- ADDR_WIDTH, 2, log2 of depth. DEPTH = 2**ADDR_WIDTH = 4 entries by default. Legal range 1..8.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write request for this cycle
- wdata  input  DATA_WIDTH  word to write when `wr_en` is accepted
- rd_en  input  1  read request for this cycle
- rdata  output  DATA_WIDTH  registered read data, valid the cycle after an accepted read
- full  output  1  high when DEPTH words are stored
- empty  output  1  high when 0 words are stored
- overflow  output  1  one-cycle pulse: `wr_en` was asserted while `full`
- underflow  output  1  one-cycle pulse: `rd_en` was asserted while `empty`

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high, port name `reset`.
- Reset values while `reset` is high, effective immediately:
  - wptr = 0, rptr = 0, rdata = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
  - Storage array is not reset.
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits. The MSB is a wrap bit and the low bits index storage.
- Flags: `empty` = (wptr == rptr); `full` = (low bits equal and MSBs differ). Both are derived combinationally from the registered pointers.
- Write accepted = wr_en & ~full:
  - mem[wptr low bits] <= wdata; wptr <= wptr + 1.
  - Wrap is natural modulo 2**(ADDR_WIDTH+1).
- Read accepted = rd_en & ~empty: rdata <= mem[rptr low bits]; rptr <= rptr + 1.
- Read latency: data is visible on `rdata` 1 cycle after the accepting edge. `rdata` holds its value when no read is accepted.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, occupancy unchanged.
  - Empty: write accepted; read rejected, no bypass of wdata to rdata; underflow pulses.
  - Full: read accepted; write rejected, based on `full` before the edge; overflow pulses.
- Rejected operations:
  - Rejected write: no state change except the overflow pulse. The word is dropped.
  - Rejected read: rdata unchanged; underflow pulse.
- Pulse timing: overflow and underflow are registered, high for exactly the cycle after the offending edge, and deasserted otherwise.
- Reset asserted mid-operation: all stored words are discarded logically (pointers cleared) and `rdata` returns to 0 asynchronously. The first accepted write after reset is read first.
- Storage is implemented as a register array with no read-during-write hazard: a read and a write to different entries at the same edge are independent. A read and a write to the same entry cannot occur unless empty, and a read while empty is rejected.

Optional Feature:
- Macro: SYNC_FIFO_RD_COUNT_EN.
- When defined:
  - Adds output port `count` [ADDR_WIDTH:0] = wptr - rptr, the number of stored words 0..DEPTH, combinational from the pointers.
  - Reset value 0.
- When undefined: the port is absent and there is no extra logic. All other behaviour is identical.

Decomposition:
- Shared package `fifo_pkg`:
  - constant DATA_WIDTH_DEF = 32.
  - constant ADDR_WIDTH_DEF = 2.
  - typedef ptr_t as logic [ADDR_WIDTH_DEF:0] for the pointer width.
- One sub-module, `fifo_ptr`: a pointer register with increment-on-enable plus wrap bit, instantiated twice (write and read). The flag logic stays in the top.

Test Plan (DEPTH=4):
- Reset then idle: rdata=0, empty=1, full=0, overflow=underflow=0 for 5 cycles.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles: full=1 after the 4th edge. Then 4 reads: rdata=0x11,0x22,0x33,0x44, each one cycle after its read edge; empty=1 after the last.
- Full plus one more write of 0x55: overflow high for 1 cycle, contents unchanged. Subsequent reads never return 0x55.
- Empty plus rd_en: underflow pulse, rdata holds the previous value. Simultaneous wr 0xAA/rd while empty: empty drops, rdata unchanged; the next read returns 0xAA.
- Wrap-around: 10 interleaved writes (0x1..0xA) and reads with occupancy kept at 2. All values return in order, and pointers pass the wrap boundary twice.
- Reset asserted mid-stream with 3 words stored: rdata=0 and empty=1 without waiting for a clock edge. After release, write 0x77 then read returns 0x77.
